// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write bus for the instruction loader.
// The master side feeds bytes and watches writes; the slave side is the loader.
interface instr_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_loader.sv
// Boot loader: receives a length-prefixed big-endian word stream and writes it
// into instruction memory, holding the CPU until a load completes.
module instr_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  instr_loader_if.slave bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] nwords_q, nwords_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        ready;
  logic        accept;
  logic [15:0] len_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      nwords_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      asm_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      nwords_q <= nwords_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      asm_q    <= asm_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Ready is a pure function of state, so no combinational path from valid.
  assign ready    = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA);
  assign accept   = ready && bus.byte_valid;
  assign len_full = {nwords_q[15:8], bus.byte_in};

  always_comb begin
    state_d  = state_q;
    nwords_d = nwords_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    asm_d    = asm_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) state_d = LEN_HI;
      end
      LEN_HI: begin
        if (accept) begin
          nwords_d = {bus.byte_in, 8'h00};
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          nwords_d = len_full;
          if (len_full == 16'd0) begin
            state_d = DONE;
          end else if (32'(len_full) > MAX_WORDS) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      DATA: begin
        if (accept) begin
          asm_d = {asm_q[15:0], bus.byte_in};
          cnt_d = cnt_q + 2'd1;
          // Address and word are latched here so they hold after WRITE.
          if (cnt_q == 2'd3) begin
            wdata_d = {asm_q, bus.byte_in};
            addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (idx_q == nwords_q - 16'd1) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.byte_ready = ready;
  assign bus.imem_we    = (state_q == WRITE);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_hold       = (state_q != DONE);
  assign done           = (state_q == DONE);
  assign error          = (state_q == ERR);

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: table of whole-load vectors plus hand-written
// sequences for gapped streams, mid-load reset and stray start pulses.
module tb_instr_loader;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic cpu_hold, done, error;

  instr_loader_if bus_if ();

  instr_loader #(.BASE_ADDR(BASE), .MAX_WORDS(256)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus_if),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  always @(negedge clk) begin
    if (bus_if.imem_we) begin
      wr_addr.push_back(bus_if.imem_addr);
      wr_data.push_back(bus_if.imem_wdata);
    end
  end

  typedef struct {
    logic [15:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[6];
  int   passed = 0;
  int   total  = 0;
  int   c0     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] word_of(input vec_t v, input int unsigned i);
    if (i == 0) return v.w0;
    if (i == 1) return v.w1;
    return 32'hA500_0000 ^ i;
  endfunction

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c0 = cyc;
  endtask

  // Called just after a negedge; returns just after the negedge following the accepting edge.
  task automatic send(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    bus_if.byte_in    = b;
    bus_if.byte_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      ok = bus_if.byte_ready;
      @(negedge clk);
    end
    if (!ok) begin
      total++;
      $display("FAIL send_timeout: byte %h not accepted, required within 50 cycles", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[31:24]);
    send(w[23:16]);
    send(w[15:8]);
    send(w[7:0]);
  endtask

  task automatic wait_end();
    for (int t = 0; t < 10; t++) begin
      if (done || error) break;
      @(negedge clk);
    end
  endtask

  task automatic chk_writes(input string name, input int n, input logic [31:0] w0, input logic [31:0] w1);
    chk({name, "_wr_count"}, 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      chk({name, "_addr"}, wr_addr[i], BASE + 32'(4 * i));
      chk({name, "_data"}, wr_data[i], (i == 0) ? w0 : (i == 1) ? w1 : (32'hA500_0000 ^ i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{n: 16'd2,      w0: 32'h1234_5678, w1: 32'h8C01_0004, err: 1'b0, lat: 12};
    vecs[1] = '{n: 16'd0,      w0: 32'h0,         w1: 32'h0,         err: 1'b0, lat: 2};
    vecs[2] = '{n: 16'h0101,   w0: 32'h0,         w1: 32'h0,         err: 1'b1, lat: 2};
    vecs[3] = '{n: 16'd1,      w0: 32'hDEAD_BEEF, w1: 32'h0,         err: 1'b0, lat: 7};
    vecs[4] = '{n: 16'd256,    w0: 32'h0102_0304, w1: 32'hF0E0_D0C0, err: 1'b0, lat: 1282};
    vecs[5] = '{n: 16'hFFFF,   w0: 32'h0,         w1: 32'h0,         err: 1'b1, lat: 2};

    rst_n = 1'b0;
    start = 1'b0;
    bus_if.byte_in    = 8'h00;
    bus_if.byte_valid = 1'b0;
    #1;
    chk("rst_ready", 32'(bus_if.byte_ready), 32'd0);
    chk("rst_we",    32'(bus_if.imem_we),    32'd0);
    chk("rst_addr",  bus_if.imem_addr,       32'd0);
    chk("rst_wdata", bus_if.imem_wdata,      32'd0);
    chk("rst_hold",  32'(cpu_hold),          32'd1);
    chk("rst_done",  32'(done),              32'd0);
    chk("rst_error", 32'(error),             32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_if.byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_start_ready", 32'(bus_if.byte_ready), 32'd0);
    bus_if.byte_valid = 1'b0;

    for (int v = 0; v < 6; v++) begin
      int nw;
      wr_addr.delete();
      wr_data.delete();
      do_start();
      send(vecs[v].n[15:8]);
      send(vecs[v].n[7:0]);
      if (!vecs[v].err)
        for (int unsigned i = 0; i < 32'(vecs[v].n); i++) send_word(word_of(vecs[v], i));
      bus_if.byte_valid = 1'b0;
      wait_end();
      nw = vecs[v].err ? 0 : int'(vecs[v].n);
      chk($sformatf("v%0d_latency", v), 32'(cyc - c0), 32'(vecs[v].lat));
      chk($sformatf("v%0d_done", v),    32'(done),     32'(!vecs[v].err));
      chk($sformatf("v%0d_error", v),   32'(error),    32'(vecs[v].err));
      chk($sformatf("v%0d_hold", v),    32'(cpu_hold), 32'(vecs[v].err));
      chk($sformatf("v%0d_ready", v),   32'(bus_if.byte_ready), 32'd0);
      chk_writes($sformatf("v%0d", v), nw, vecs[v].w0, vecs[v].w1);
    end

    // Gapped stream, then a byte offered while the word is being written.
    wr_addr.delete();
    wr_data.delete();
    do_start();
    send(8'h00);
    bus_if.byte_valid = 1'b0;
    @(negedge clk);
    send(8'h01);
    bus_if.byte_valid = 1'b0;
    @(negedge clk);
    send(8'hCA);
    bus_if.byte_valid = 1'b0;
    @(negedge clk);
    send(8'hFE);
    bus_if.byte_valid = 1'b0;
    @(negedge clk);
    send(8'hBA);
    bus_if.byte_valid = 1'b0;
    @(negedge clk);
    send(8'hBE);
    bus_if.byte_in    = 8'hEE;
    bus_if.byte_valid = 1'b1;
    chk("gap_ready_in_write", 32'(bus_if.byte_ready), 32'd0);
    chk("gap_we_in_write",    32'(bus_if.imem_we),    32'd1);
    @(negedge clk);
    bus_if.byte_valid = 1'b0;
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_we_after", 32'(bus_if.imem_we), 32'd0);
    chk("gap_wdata_held", bus_if.imem_wdata, 32'hCAFE_BABE);
    chk_writes("gap", 1, 32'hCAFE_BABE, 32'h0);

    // Reset in the middle of word 1 of a 3-word load.
    wr_addr.delete();
    wr_data.delete();
    do_start();
    send(8'h00);
    send(8'h03);
    send_word(32'h1122_3344);
    send(8'h55);
    send(8'h66);
    bus_if.byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus_if.byte_ready), 32'd0);
    chk("mid_rst_we",    32'(bus_if.imem_we),    32'd0);
    chk("mid_rst_addr",  bus_if.imem_addr,       32'd0);
    chk("mid_rst_wdata", bus_if.imem_wdata,      32'd0);
    chk("mid_rst_hold",  32'(cpu_hold),          32'd1);
    chk("mid_rst_done",  32'(done),              32'd0);
    chk_writes("mid_rst", 1, 32'h1122_3344, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_idle_ready", 32'(bus_if.byte_ready), 32'd0);
    chk("mid_rst_idle_hold",  32'(cpu_hold),          32'd1);
    chk_writes("mid_rst_after", 1, 32'h1122_3344, 32'h0);

    // Stray start pulse while receiving data.
    wr_addr.delete();
    wr_data.delete();
    do_start();
    send(8'h00);
    send(8'h02);
    send(8'h12);
    send(8'h34);
    start = 1'b1;
    send(8'h56);
    start = 1'b0;
    send(8'h78);
    send_word(32'h8C01_0004);
    bus_if.byte_valid = 1'b0;
    wait_end();
    chk("restart_latency", 32'(cyc - c0), 32'd12);
    chk("restart_done",    32'(done),     32'd1);
    chk_writes("restart", 2, 32'h1234_5678, 32'h8C01_0004);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address at which word 0 is written.
REQ-002 SHALL have parameter MAX_WORDS, default 256, meaning the largest legal word count.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins a load.
REQ-006 SHALL have port byte_in, input, 8, the incoming stream byte.
REQ-007 SHALL have port byte_valid, input, 1, meaning byte_in holds a valid byte.
REQ-008 SHALL have port byte_ready, output, 1, meaning the loader accepts byte_in this cycle.
REQ-009 SHALL have port imem_we, output, 1, the instruction-memory write strobe.
REQ-010 SHALL have port imem_addr, output, 32, the word-aligned byte address for the write.
REQ-011 SHALL have port imem_wdata, output, 32, the instruction word to write.
REQ-012 SHALL have port cpu_hold, output, 1, which holds the processor (fetch/PC) while high.
REQ-013 SHALL have port done, output, 1, high when a load has completed successfully.
REQ-014 SHALL have port error, output, 1, high when a load has been rejected.

Function
REQ-015 SHALL implement the states IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE and ERR.
REQ-016 SHALL accept a byte only on an edge where byte_valid and byte_ready are both 1; byte_valid without byte_ready SHALL have no effect.
REQ-017 SHALL drive byte_ready=1 only in LEN_HI, LEN_LO and DATA, with byte_ready depending only on the current state (no combinational path from byte_valid).
REQ-018 SHALL use the following stream format: a 16-bit word count N (high byte first), then 4N bytes, each word big-endian (first byte is bits [31:24]).
REQ-019 SHALL go IDLE/DONE/ERR -> LEN_HI on start=1; start SHALL be ignored in every other state.
REQ-020 SHALL go LEN_HI -> LEN_LO on accept, capturing N[15:8].
REQ-021 SHALL resolve LEN_LO on accept as follows: N==0 -> DONE; N>MAX_WORDS -> ERR; otherwise -> DATA, with word index=0 and byte counter=0.
REQ-022 SHALL, in DATA, shift each accepted byte into the assembly register; the 4th accepted byte SHALL move to WRITE on the same edge, with the word complete.
REQ-023 SHALL assert imem_we for exactly one cycle in WRITE, with imem_addr = BASE_ADDR + 4*index (32-bit, wrapping) and imem_wdata = the assembled word.
REQ-024 SHALL leave WRITE as follows: if index==N-1 -> DONE; otherwise index+1 -> DATA.
REQ-025 SHALL hold imem_we=0 outside WRITE; imem_addr and imem_wdata SHALL then hold their last values.
REQ-026 SHALL keep the word index at 16 bits and the byte counter at 2 bits.
REQ-027 SHALL drive cpu_hold=1 in every state except DONE, so that the CPU runs only after a successful load.
REQ-028 SHALL hold done=1 only in DONE and error=1 only in ERR; both are levels that clear when start leaves the state.
REQ-029 SHALL have a minimum load time for N words of 2 + 5N cycles after start, given byte_valid held at 1.
REQ-030 SHALL tolerate gaps in byte_valid of any length in any receiving state, with no timeout.

Reset
REQ-031 SHALL, while rst_n=0, force state=IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0, and index/counter/assembly=0.
REQ-032 SHALL, when rst_n is asserted mid-load, abort immediately; partial words SHALL NOT be written, and already-written words SHALL remain in memory.
REQ-033 SHALL, after rst_n deassertion, remain in IDLE until start.

Verification
REQ-034 SHALL pass this scenario: start, stream 00 02 12 34 56 78 8C 01 00 04 at valid=1 -> writes 0x12345678@0x0, then 0x8C010004@0x4; done=1 and cpu_hold=0 at cycle 12 after start.
REQ-035 SHALL pass this scenario: start, stream 00 00 -> no imem_we; done=1 on the cycle after the 2nd byte.
REQ-036 SHALL pass this scenario: MAX_WORDS=256, stream 01 01 -> error=1, cpu_hold=1, no writes; a subsequent start with a valid stream loads normally.
REQ-037 SHALL pass this scenario: N=1 with byte_valid toggled 1/0 each cycle -> exactly one write of the correct word; byte_ready=0 in WRITE, so extra bytes offered there are not consumed.
REQ-038 SHALL pass this scenario: N=3, rst_n pulsed low after the 6th data byte -> only word 0 written, outputs at reset values, state IDLE.
REQ-039 SHALL pass this scenario: start pulsed again during DATA -> ignored; the load completes with unchanged addresses and data.
